reg_file_ctrl: RTL

Command-sequencing controller for the system register file. It parses a byte stream of write and read commands from the receive side and issues single-cycle `WrEn`/`RdEn` strobes with address and data to the register file. It captures read results and hands them to the transmit side over a valid/ready handshake. It sits between the serial receiver, the register file and the serial transmitter, all in one clock domain.

---
 rtl/reg_file_ctrl_pkg.sv | 10 +
 rtl/reg_file_ctrl_if.sv | 27 ++
 rtl/reg_file_ctrl_frame_timer.sv | 35 +++
 rtl/reg_file_ctrl.sv | 128 ++++++++++++
 4 files changed

// File: rtl/reg_file_ctrl_pkg.sv
// Shared definitions for the register-file command controller:
// command byte values and the FSM state encoding.
package reg_file_ctrl_pkg;
  localparam logic [7:0] WR_CMD = 8'hAA;
  localparam logic [7:0] RD_CMD = 8'hBB;

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, RD_CAP, RD_SEND
  } state_e;
endpackage

// File: rtl/reg_file_ctrl_if.sv
// Bus bundle between the controller (slave view) and the receiver,
// register file and transmitter around it (master view).
interface reg_file_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic [DATA_WIDTH-1:0] RX_P_DATA;
  logic                  RX_D_VLD;
  logic                  WrEn;
  logic                  RdEn;
  logic [ADDR_WIDTH-1:0] Address;
  logic [DATA_WIDTH-1:0] WrData;
  logic [DATA_WIDTH-1:0] RdData;
  logic [DATA_WIDTH-1:0] TX_P_DATA;
  logic                  TX_D_VLD;
  logic                  TX_READY;
  logic                  FRAME_ERR;

  modport slave (
    input  RX_P_DATA, RX_D_VLD, RdData, TX_READY,
    output WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, FRAME_ERR
  );
  modport master (
    output RX_P_DATA, RX_D_VLD, RdData, TX_READY,
    input  WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, FRAME_ERR
  );
endinterface

// File: rtl/reg_file_ctrl_frame_timer.sv
// Inter-byte idle counter; expired is asserted combinationally during the
// TIMEOUT-th consecutive enabled cycle without a clear. TIMEOUT=0 disables it.
module frame_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  generate
    if (TIMEOUT == 0) begin : g_off
      logic unused_in;
      assign unused_in = ^{clk, rst_n, clear, enable};
      assign expired   = 1'b0;
    end else begin : g_on
      localparam int CW = $clog2(TIMEOUT + 1);
      logic [CW-1:0] cnt_q, cnt_d;

      assign expired = enable && !clear && (cnt_q == CW'(TIMEOUT - 1));

      always_comb begin
        cnt_d = cnt_q;
        if (clear || !enable) cnt_d = '0;
        else if (!expired)    cnt_d = cnt_q + CW'(1);
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
      end
    end
  endgenerate
endmodule

// File: rtl/reg_file_ctrl.sv
// Parses AA/BB command frames from the receiver into single-cycle register
// file strobes and forwards read results to the transmitter.
module reg_file_ctrl
  import reg_file_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int TIMEOUT    = 255
) (
  input logic           CLK,
  input logic           RST,
  reg_file_ctrl_if.slave bus
);
  state_e                state_q, state_d;
  logic                  wr_en_q, wr_en_d, rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0] address_q, address_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d, tx_data_q, tx_data_d;
  logic                  tx_vld_q, tx_vld_d, frame_err_q, frame_err_d;
  logic                  tmr_active, tmr_expired, addr_bad;

  // Every entry into a timed state coincides with a received byte, so the
  // byte strobe alone provides the clear-on-entry.
  assign tmr_active = state_q inside {WR_ADDR, WR_DATA, RD_ADDR};

  frame_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (CLK),
    .rst_n   (RST),
    .clear   (bus.RX_D_VLD),
    .enable  (tmr_active),
    .expired (tmr_expired)
  );

  assign addr_bad = (bus.RX_P_DATA >> ADDR_WIDTH) != '0;

  always_comb begin
    state_d     = state_q;
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;
    address_d   = address_q;
    wr_data_d   = wr_data_q;
    tx_data_d   = tx_data_q;
    tx_vld_d    = tx_vld_q;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: if (bus.RX_D_VLD) begin
        if (bus.RX_P_DATA == DATA_WIDTH'(WR_CMD))      state_d = WR_ADDR;
        else if (bus.RX_P_DATA == DATA_WIDTH'(RD_CMD)) state_d = RD_ADDR;
        else                                           frame_err_d = 1'b1;
      end
      WR_ADDR, RD_ADDR: begin
        if (bus.RX_D_VLD) begin
          address_d = bus.RX_P_DATA[ADDR_WIDTH-1:0];
          if (addr_bad) begin
            frame_err_d = 1'b1;
            state_d     = IDLE;
          end else if (state_q == WR_ADDR) begin
            state_d = WR_DATA;
          end else begin
            rd_en_d = 1'b1;
            state_d = RD_WAIT;
          end
        end else if (tmr_expired) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end
      end
      WR_DATA: begin
        if (bus.RX_D_VLD) begin
          wr_data_d = bus.RX_P_DATA;
          wr_en_d   = 1'b1;
          state_d   = IDLE;
        end else if (tmr_expired) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end
      end
      // Bytes arriving while a read is in flight are dropped and flagged.
      RD_WAIT: begin
        frame_err_d = bus.RX_D_VLD;
        state_d     = RD_CAP;
      end
      RD_CAP: begin
        frame_err_d = bus.RX_D_VLD;
        tx_data_d   = bus.RdData;
        tx_vld_d    = 1'b1;
        state_d     = RD_SEND;
      end
      RD_SEND: begin
        frame_err_d = bus.RX_D_VLD;
        if (bus.TX_READY) begin
          tx_vld_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      address_q   <= '0;
      wr_data_q   <= '0;
      tx_data_q   <= '0;
      tx_vld_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      address_q   <= address_d;
      wr_data_q   <= wr_data_d;
      tx_data_q   <= tx_data_d;
      tx_vld_q    <= tx_vld_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.WrEn      = wr_en_q;
  assign bus.RdEn      = rd_en_q;
  assign bus.Address   = address_q;
  assign bus.WrData    = wr_data_q;
  assign bus.TX_P_DATA = tx_data_q;
  assign bus.TX_D_VLD  = tx_vld_q;
  assign bus.FRAME_ERR = frame_err_q;
endmodule
